conv_scan: RTL and testbench
============================

# conv_scan

Window scanner and operand sequencer feeding `conv_cal`. It snapshots one image and one kernel on `start`, then walks every output position in row-major order, and every kernel tap within each position. Each cycle it presents one pixel/weight operand pair, together with the result coordinates and the accumulator control strobes (`conv_on`, `chge_rlt`, `chge_rlt_q`, `srh_fin`) that `conv_cal` consumes. Zero padding is applied here, so the downstream multiply-accumulate never sees out-of-range addresses.

## Interface
- `weight_width`, 2, kernel columns (WW)
- `weight_height`, 2, kernel rows (WH)
- `img_width`, 4, image columns (IW)
- `img_height`, 4, image rows (IH)
- `padding_enable`, 0, 1 = apply zero border of `padding` pixels
- `padding`, 0, border width P; effective P = 0 when `padding_enable` = 0
- `stride`, 1, window step S in both axes
- `bitwidth`, 3, operand width B
- `flush_cycles`, 2, accumulator pipeline drain cycles F (≥1)
- `result_width`, (IW−WW+2P)/S+1, output columns RW (≤16)
- `result_height`, (IH−WH+2P)/S+1, output rows RH (≤16)

Ports:
- `clk_en` input 1: clock; all logic on rising edge
- `rst_n` input 1: synchronous, active-low reset
- `start` input 1: request a new convolution; accepted only in IDLE
- `img_data` input IW·IH·B: image, pixel (r,c) at bits `(r·IW+c)·B +: B`
- `wei_data` input WW·WH·B: kernel, tap (kl,kc) at bits `(kl·WW+kc)·B +: B`
- `busy` output 1: high in SCAN and FLUSH
- `conv_on` output 1: accumulator enable
- `chge_rlt` output 1: first tap of a window (accumulator reload)
- `chge_rlt_q` output 1: `chge_rlt` delayed one cycle
- `rlt_l` output 4: result row of current tap
- `rlt_c` output 4: result column of current tap
- `img_cal` output B: pixel operand
- `wei_cal` output B: weight operand
- `srh_fin` output 1: one-cycle end-of-frame pulse

## Operation
- Counters: `kc` (0..WW−1), `kl` (0..WH−1), `rlt_c` (0..RW−1), `rlt_l` (0..RH−1). `kc` is the fastest; `rlt_l` is the slowest.
- States: IDLE, SCAN, FLUSH, FIN.
  - IDLE → SCAN on `start`. Same edge: snapshot `img_data`/`wei_data` into internal registers and clear all counters.
  - SCAN: advance `kc`, with carry into `kl`, `rlt_c`, `rlt_l`. On the last tap of the last window (all counters at max), go to FLUSH.
  - FLUSH: lasts exactly F cycles, then go to FIN.
  - FIN: one cycle, then IDLE.
- Operands are driven combinationally from the snapshot registers and counters; no input-to-output path exists.
  - `wei_cal` = tap (kl,kc).
  - `img_cal` = pixel (r,c), where r = rlt_l·S + kl − P and c = rlt_c·S + kc − P.
  - `img_cal` = 0 if r or c lies outside 0..IH−1 / 0..IW−1. Use signed compare, or an offset of P to avoid underflow.
- SCAN outputs: `conv_on` = 1; `chge_rlt` = (kl==0 && kc==0); `rlt_l`/`rlt_c` = current window.
- FLUSH outputs:
  - `conv_on` = 1; `img_cal` = `wei_cal` = 0; `chge_rlt` = 0.
  - `rlt_l` = RH−1 and `rlt_c` = RW−1 are held, so the last result is written after the pipeline drains.
- FIN outputs: `srh_fin` = 1; `conv_on` = 0; `busy` = 0.
- IDLE outputs: `conv_on` = `chge_rlt` = `srh_fin` = 0; operands = 0; `rlt_l`/`rlt_c` = 0.
- `chge_rlt_q` is a flop of `chge_rlt`, cleared by reset.
- `start` during SCAN, FLUSH or FIN is ignored; no queueing.
- `start` in the FIN cycle is ignored. A new frame starts at the earliest in the first IDLE cycle after FIN.
- Input changes after acceptance do not affect the running frame.

## Timing
- Reset (`rst_n` = 0 at an edge): state IDLE, all counters 0, all outputs 0. This includes `chge_rlt_q` and the snapshot registers. Reset mid-frame aborts immediately, and no `srh_fin` is produced.
- `start` sampled high at edge E0: the first tap is visible in the cycle after E0, with `conv_on` = 1 and `chge_rlt` = 1.
- SCAN length: RW·RH·WW·WH cycles (36 with defaults). Then F cycles of FLUSH, then 1 cycle of FIN.
- Frame length, from the cycle after E0 to `srh_fin` inclusive: RW·RH·WW·WH + F + 1 cycles (39 with defaults).
- `chge_rlt` pulses once every WW·WH cycles in SCAN, exactly RW·RH times per frame.
- `busy` rises in the cycle after E0 and falls in the FIN cycle.

## Test plan
- Defaults; pixel (r,c) = (r+c) mod 8; weights all 1; `start` for one cycle.
  - Window (0,0) `img_cal` sequence is 0,1,1,2, with `chge_rlt` = 1 on the first tap only.
  - Window (2,2) sequence is 4,5,5,6.
  - `srh_fin` arrives exactly 39 cycles after the first tap.
- Same image, `padding_enable` = 1, P = 1 (RW = RH = 5).
  - Window (0,0) `img_cal` sequence is 0,0,0,0.
  - Window (0,1) sequence is 0,0,0,1.
  - SCAN lasts 100 cycles.
- `stride` = 2, IW = IH = 4, WW = WH = 2 (RW = RH = 2).
  - `rlt_c`/`rlt_l` visit (0,0),(0,1),(1,0),(1,1).
  - Window (1,1) pixels are (2,2),(2,3),(3,2),(3,3).
- Assert `start` again mid-SCAN and during FIN: the running frame's length and sequence are unchanged. A `start` in the cycle after FIN begins a new frame.
- `rst_n` low at SCAN cycle 10: the next cycle shows all outputs 0 and no `srh_fin`. A subsequent `start` replays from window (0,0).
- Change `img_data` to all-7 during SCAN: `img_cal` still follows the snapshot values. `chge_rlt_q` lags `chge_rlt` by exactly one cycle throughout.

Source files
------------

// File: rtl/conv_scan.sv
// Window scanner / operand sequencer for conv_cal: snapshots one image and kernel,
// then presents one zero-padded pixel/weight pair per cycle with accumulator strobes.
module conv_scan #(
  parameter int unsigned weight_width   = 2,
  parameter int unsigned weight_height  = 2,
  parameter int unsigned img_width      = 4,
  parameter int unsigned img_height     = 4,
  parameter int unsigned padding_enable = 0,
  parameter int unsigned padding        = 0,
  parameter int unsigned stride         = 1,
  parameter int unsigned bitwidth       = 3,
  parameter int unsigned flush_cycles   = 2
) (
  input  logic                                         clk_en,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [img_width*img_height*bitwidth-1:0]     img_data,
  input  logic [weight_width*weight_height*bitwidth-1:0] wei_data,
  output logic                                         busy,
  output logic                                         conv_on,
  output logic                                         chge_rlt,
  output logic                                         chge_rlt_q,
  output logic [3:0]                                   rlt_l,
  output logic [3:0]                                   rlt_c,
  output logic [bitwidth-1:0]                          img_cal,
  output logic [bitwidth-1:0]                          wei_cal,
  output logic                                         srh_fin
);

  localparam int unsigned P_EFF         = (padding_enable != 0) ? padding : 0;
  localparam int unsigned result_width  = (img_width + 2 * P_EFF - weight_width) / stride + 1;
  localparam int unsigned result_height = (img_height + 2 * P_EFF - weight_height) / stride + 1;
  localparam int unsigned KCW      = (weight_width > 1) ? $clog2(weight_width) : 1;
  localparam int unsigned KLW      = (weight_height > 1) ? $clog2(weight_height) : 1;
  localparam int unsigned PIX_N    = img_width * img_height;
  localparam int unsigned PIX_AW   = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam int unsigned WEI_N    = weight_width * weight_height;
  localparam int unsigned WEI_AW   = (WEI_N > 1) ? $clog2(WEI_N) : 1;
  localparam int unsigned FCW      = $clog2(flush_cycles + 1);
  localparam int unsigned CW       = 16;
  localparam int unsigned IMG_BITS = PIX_N * bitwidth;
  localparam int unsigned WEI_BITS = WEI_N * bitwidth;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [KCW-1:0]       kc_q, kc_d;
  logic [KLW-1:0]       kl_q, kl_d;
  logic [3:0]           rc_q, rc_d;
  logic [3:0]           rl_q, rl_d;
  logic [FCW-1:0]       flush_q, flush_d;
  logic [IMG_BITS-1:0]  img_q, img_d;
  logic [WEI_BITS-1:0]  wei_q, wei_d;
  logic                 chge_dly_q, chge_dly_d;

  logic                 kc_last, kl_last, rc_last, rl_last;
  logic [bitwidth-1:0]  pix [PIX_N];
  logic [bitwidth-1:0]  wei [WEI_N];
  logic [CW-1:0]        r_off, c_off, row, col;
  logic                 in_img;
  logic [PIX_AW-1:0]    pix_idx;
  logic [WEI_AW-1:0]    wei_idx;

  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      kc_q       <= '0;
      kl_q       <= '0;
      rc_q       <= '0;
      rl_q       <= '0;
      flush_q    <= '0;
      img_q      <= '0;
      wei_q      <= '0;
      chge_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kc_q       <= kc_d;
      kl_q       <= kl_d;
      rc_q       <= rc_d;
      rl_q       <= rl_d;
      flush_q    <= flush_d;
      img_q      <= img_d;
      wei_q      <= wei_d;
      chge_dly_q <= chge_dly_d;
    end
  end

  assign kc_last = (kc_q == KCW'(weight_width - 1));
  assign kl_last = (kl_q == KLW'(weight_height - 1));
  assign rc_last = (rc_q == 4'(result_width - 1));
  assign rl_last = (rl_q == 4'(result_height - 1));

  // Next-state: counters nest kc -> kl -> rlt_c -> rlt_l; they hold on the final tap.
  always_comb begin
    state_d    = state_q;
    kc_d       = kc_q;
    kl_d       = kl_q;
    rc_d       = rc_q;
    rl_d       = rl_q;
    flush_d    = flush_q;
    img_d      = img_q;
    wei_d      = wei_q;
    chge_dly_d = chge_rlt;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          img_d   = img_data;
          wei_d   = wei_data;
          kc_d    = '0;
          kl_d    = '0;
          rc_d    = '0;
          rl_d    = '0;
        end
      end
      S_SCAN: begin
        if (kc_last && kl_last && rc_last && rl_last) begin
          state_d = S_FLUSH;
          flush_d = '0;
        end else begin
          kc_d = kc_last ? '0 : kc_q + KCW'(1);
          if (kc_last) begin
            kl_d = kl_last ? '0 : kl_q + KLW'(1);
            if (kl_last) begin
              rc_d = rc_last ? '0 : rc_q + 4'(1);
              if (rc_last) begin
                rl_d = rl_q + 4'(1);
              end
            end
          end
        end
      end
      S_FLUSH: begin
        flush_d = flush_q + FCW'(1);
        if (flush_q == FCW'(flush_cycles - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Unpack snapshot vectors into per-pixel / per-tap arrays.
  for (genvar g = 0; g < PIX_N; g++) begin : g_pix
    assign pix[g] = img_q[g*bitwidth +: bitwidth];
  end
  for (genvar g = 0; g < WEI_N; g++) begin : g_wei
    assign wei[g] = wei_q[g*bitwidth +: bitwidth];
  end

  // Coordinates carry a +P offset; subtracting P wraps negatives past the image bound.
  always_comb begin
    r_off   = CW'(rl_q) * CW'(stride) + CW'(kl_q);
    c_off   = CW'(rc_q) * CW'(stride) + CW'(kc_q);
    row     = r_off - CW'(P_EFF);
    col     = c_off - CW'(P_EFF);
    in_img  = (row < CW'(img_height)) && (col < CW'(img_width));
    pix_idx = PIX_AW'(row * CW'(img_width) + col);
    wei_idx = WEI_AW'(CW'(kl_q) * CW'(weight_width) + CW'(kc_q));
  end

  always_comb begin
    busy     = 1'b0;
    conv_on  = 1'b0;
    chge_rlt = 1'b0;
    srh_fin  = 1'b0;
    rlt_l    = '0;
    rlt_c    = '0;
    img_cal  = '0;
    wei_cal  = '0;
    case (state_q)
      S_SCAN: begin
        busy     = 1'b1;
        conv_on  = 1'b1;
        chge_rlt = (kc_q == '0) && (kl_q == '0);
        rlt_l    = rl_q;
        rlt_c    = rc_q;
        wei_cal  = wei[wei_idx];
        img_cal  = in_img ? pix[pix_idx] : '0;
      end
      S_FLUSH: begin
        busy    = 1'b1;
        conv_on = 1'b1;
        rlt_l   = 4'(result_height - 1);
        rlt_c   = 4'(result_width - 1);
      end
      S_FIN:   srh_fin = 1'b1;
      default: ;
    endcase
  end

  assign chge_rlt_q = chge_dly_q;

endmodule

// File: tb/tb_conv_scan.sv
// Directed bench for conv_scan: default, padded and stride-2 instances share one image.
module tb_conv_scan;

  localparam int unsigned B  = 3;
  localparam int unsigned IW = 4;
  localparam int unsigned IH = 4;

  logic              clk;
  logic              rst_n;
  logic [2:0]        start_v;
  logic [IW*IH*B-1:0] img_data;
  logic [11:0]       wei_ones;
  logic [11:0]       wei_str;

  logic       busy_w [3];
  logic       conv_w [3];
  logic       chg_w  [3];
  logic       chgq_w [3];
  logic [3:0] rl_w   [3];
  logic [3:0] rc_w   [3];
  logic [2:0] img_w  [3];
  logic [2:0] wei_w  [3];
  logic       fin_w  [3];

  int checks;
  int errors;
  int fin_n;
  int fin_cnt;
  int tr_img [128];
  int tr_wei [128];
  int tr_chg [128];
  int tr_chgq[128];
  int tr_rl  [128];
  int tr_rc  [128];
  int tr_conv[128];
  int tr_busy[128];

  conv_scan u_def (
    .clk_en(clk), .rst_n(rst_n), .start(start_v[0]), .img_data(img_data), .wei_data(wei_ones),
    .busy(busy_w[0]), .conv_on(conv_w[0]), .chge_rlt(chg_w[0]), .chge_rlt_q(chgq_w[0]),
    .rlt_l(rl_w[0]), .rlt_c(rc_w[0]), .img_cal(img_w[0]), .wei_cal(wei_w[0]), .srh_fin(fin_w[0])
  );

  conv_scan #(.padding_enable(1), .padding(1)) u_pad (
    .clk_en(clk), .rst_n(rst_n), .start(start_v[1]), .img_data(img_data), .wei_data(wei_ones),
    .busy(busy_w[1]), .conv_on(conv_w[1]), .chge_rlt(chg_w[1]), .chge_rlt_q(chgq_w[1]),
    .rlt_l(rl_w[1]), .rlt_c(rc_w[1]), .img_cal(img_w[1]), .wei_cal(wei_w[1]), .srh_fin(fin_w[1])
  );

  conv_scan #(.stride(2)) u_str (
    .clk_en(clk), .rst_n(rst_n), .start(start_v[2]), .img_data(img_data), .wei_data(wei_str),
    .busy(busy_w[2]), .conv_on(conv_w[2]), .chge_rlt(chg_w[2]), .chge_rlt_q(chgq_w[2]),
    .rlt_l(rl_w[2]), .rlt_c(rc_w[2]), .img_cal(img_w[2]), .wei_cal(wei_w[2]), .srh_fin(fin_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [IW*IH*B-1:0] make_img();
    logic [IW*IH*B-1:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v = v | ((IW*IH*B)'((r + c) % 8) << ((r * 4 + c) * 3));
    return v;
  endfunction

  // Expected pixel operand at SCAN cycle n (1-based), 2x2 kernel on the (r+c)%8 image.
  function automatic int model_img(int rw, int s, int p, int n);
    int t, kc, kl, w, r, c;
    t  = n - 1;
    kc = t % 2;
    kl = (t / 2) % 2;
    w  = t / 4;
    r  = (w / rw) * s + kl - p;
    c  = (w % rw) * s + kc - p;
    if (r < 0 || r > 3 || c < 0 || c > 3) return 0;
    return (r + c) % 8;
  endfunction

  function automatic int exp_chg(int n, int scan_len);
    return (n >= 1 && n <= scan_len && (n - 1) % 4 == 0) ? 1 : 0;
  endfunction

  task automatic capture(input logic [1:0] sel, input int ncyc, input int rs_a, input int rs_b,
                         input int rs_c, input int rst_at, input int chg_at);
    fin_n   = -1;
    fin_cnt = 0;
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      tr_img[n]  = int'(img_w[sel]);
      tr_wei[n]  = int'(wei_w[sel]);
      tr_chg[n]  = int'(chg_w[sel]);
      tr_chgq[n] = int'(chgq_w[sel]);
      tr_rl[n]   = int'(rl_w[sel]);
      tr_rc[n]   = int'(rc_w[sel]);
      tr_conv[n] = int'(conv_w[sel]);
      tr_busy[n] = int'(busy_w[sel]);
      if (fin_w[sel]) begin
        fin_cnt++;
        if (fin_n < 0) fin_n = n;
      end
      start_v[sel] = (n == rs_a || n == rs_b || n == rs_c);
      rst_n = (n != rst_at);
      if (n == chg_at) img_data = '1;
      @(negedge clk);
    end
    start_v[sel] = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    logic [1:0]  sd;
    rst_n   = 1'b0;
    start_v = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sd  = 2'(d);
      got = {busy_w[sd], conv_w[sd], chg_w[sd], chgq_w[sd], rl_w[sd], rc_w[sd],
             img_w[sd], wei_w[sd], fin_w[sd]};
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d got %h exp 0", d, got);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default();
    int e00[4] = '{0, 1, 1, 2};
    int c00[4] = '{1, 0, 0, 0};
    int e22[4] = '{4, 5, 5, 6};
    int nchg;
    capture(2'd0, 45, -1, -1, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tr_img[1+i] !== e00[i]) begin
        errors++; $display("FAIL def_w00_img tap%0d got %0d exp %0d", i, tr_img[1+i], e00[i]);
      end
      checks++;
      if (tr_chg[1+i] !== c00[i]) begin
        errors++; $display("FAIL def_w00_chg tap%0d got %0d exp %0d", i, tr_chg[1+i], c00[i]);
      end
      checks++;
      if (tr_img[33+i] !== e22[i]) begin
        errors++; $display("FAIL def_w22_img tap%0d got %0d exp %0d", i, tr_img[33+i], e22[i]);
      end
    end
    checks++;
    if (fin_n !== 39) begin
      errors++; $display("FAIL def_fin_cycle got %0d exp 39", fin_n);
    end
    checks++;
    if (fin_cnt !== 1) begin
      errors++; $display("FAIL def_fin_count got %0d exp 1", fin_cnt);
    end
    nchg = 0;
    for (int n = 1; n <= 45; n++) nchg += tr_chg[n];
    checks++;
    if (nchg !== 9) begin
      errors++; $display("FAIL def_chg_count got %0d exp 9", nchg);
    end
    for (int n = 37; n <= 38; n++) begin
      checks++;
      if ({tr_conv[n], tr_img[n], tr_wei[n], tr_chg[n], tr_rl[n], tr_rc[n], tr_busy[n]}
          !== {32'd1, 32'd0, 32'd0, 32'd0, 32'd2, 32'd2, 32'd1}) begin
        errors++;
        $display("FAIL def_flush n=%0d got conv=%0d img=%0d wei=%0d chg=%0d rl=%0d rc=%0d busy=%0d exp 1,0,0,0,2,2,1",
                 n, tr_conv[n], tr_img[n], tr_wei[n], tr_chg[n], tr_rl[n], tr_rc[n], tr_busy[n]);
      end
    end
    checks++;
    if ({tr_busy[39], tr_conv[39]} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL def_fin_busy got busy=%0d conv=%0d exp 0,0", tr_busy[39], tr_conv[39]);
    end
    for (int n = 1; n <= 45; n++) begin
      checks++;
      if (tr_chgq[n] !== exp_chg(n - 1, 36)) begin
        errors++; $display("FAIL def_chgq_lag n=%0d got %0d exp %0d", n, tr_chgq[n], exp_chg(n - 1, 36));
      end
    end
  endtask

  task automatic test_padding();
    int e01[4] = '{0, 0, 0, 1};
    int e44[4] = '{6, 0, 0, 0};
    int nchg;
    capture(2'd1, 110, -1, -1, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tr_img[1+i] !== 0) begin
        errors++; $display("FAIL pad_w00_img tap%0d got %0d exp 0", i, tr_img[1+i]);
      end
      checks++;
      if (tr_img[5+i] !== e01[i]) begin
        errors++; $display("FAIL pad_w01_img tap%0d got %0d exp %0d", i, tr_img[5+i], e01[i]);
      end
      checks++;
      if (tr_img[97+i] !== e44[i]) begin
        errors++; $display("FAIL pad_w44_img tap%0d got %0d exp %0d", i, tr_img[97+i], e44[i]);
      end
    end
    for (int n = 1; n <= 100; n++) begin
      checks++;
      if (tr_img[n] !== model_img(5, 1, 1, n)) begin
        errors++; $display("FAIL pad_img n=%0d got %0d exp %0d", n, tr_img[n], model_img(5, 1, 1, n));
      end
    end
    nchg = 0;
    for (int n = 1; n <= 110; n++) nchg += tr_chg[n];
    checks++;
    if (nchg !== 25) begin
      errors++; $display("FAIL pad_chg_count got %0d exp 25", nchg);
    end
    checks++;
    if ({tr_rl[101], tr_rc[101], tr_conv[101], tr_img[101]} !== {32'd4, 32'd4, 32'd1, 32'd0}) begin
      errors++; $display("FAIL pad_flush got rl=%0d rc=%0d conv=%0d img=%0d exp 4,4,1,0",
                         tr_rl[101], tr_rc[101], tr_conv[101], tr_img[101]);
    end
    checks++;
    if (fin_n !== 103) begin
      errors++; $display("FAIL pad_fin_cycle got %0d exp 103", fin_n);
    end
  endtask

  task automatic test_stride();
    int erl[4] = '{0, 0, 1, 1};
    int erc[4] = '{0, 1, 0, 1};
    int e01[4] = '{2, 3, 3, 4};
    int e11[4] = '{4, 5, 5, 6};
    int ew [4] = '{1, 2, 3, 4};
    capture(2'd2, 25, -1, -1, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tr_rl[1+4*i], tr_rc[1+4*i]} !== {erl[i], erc[i]}) begin
        errors++; $display("FAIL str_window%0d got (%0d,%0d) exp (%0d,%0d)",
                           i, tr_rl[1+4*i], tr_rc[1+4*i], erl[i], erc[i]);
      end
      checks++;
      if (tr_img[5+i] !== e01[i]) begin
        errors++; $display("FAIL str_w01_img tap%0d got %0d exp %0d", i, tr_img[5+i], e01[i]);
      end
      checks++;
      if (tr_img[13+i] !== e11[i]) begin
        errors++; $display("FAIL str_w11_img tap%0d got %0d exp %0d", i, tr_img[13+i], e11[i]);
      end
      checks++;
      if (tr_wei[13+i] !== ew[i]) begin
        errors++; $display("FAIL str_w11_wei tap%0d got %0d exp %0d", i, tr_wei[13+i], ew[i]);
      end
    end
    checks++;
    if (fin_n !== 19) begin
      errors++; $display("FAIL str_fin_cycle got %0d exp 19", fin_n);
    end
  endtask

  task automatic test_restart();
    capture(2'd0, 45, 10, 39, 40, -1, -1);
    for (int n = 1; n <= 36; n++) begin
      checks++;
      if (tr_img[n] !== model_img(3, 1, 0, n)) begin
        errors++; $display("FAIL rst_img n=%0d got %0d exp %0d", n, tr_img[n], model_img(3, 1, 0, n));
      end
    end
    checks++;
    if (fin_n !== 39 || fin_cnt !== 1) begin
      errors++; $display("FAIL restart_fin got cycle=%0d count=%0d exp 39,1", fin_n, fin_cnt);
    end
    checks++;
    if (tr_busy[40] !== 0) begin
      errors++; $display("FAIL restart_idle_after_fin got busy=%0d exp 0", tr_busy[40]);
    end
    checks++;
    if ({tr_busy[41], tr_chg[41], tr_img[41], tr_img[42]} !== {32'd1, 32'd1, 32'd0, 32'd1}) begin
      errors++; $display("FAIL restart_new_frame got busy=%0d chg=%0d img=%0d,%0d exp 1,1,0,1",
                         tr_busy[41], tr_chg[41], tr_img[41], tr_img[42]);
    end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int sum;
    int e00[4] = '{0, 1, 1, 2};
    capture(2'd0, 50, -1, -1, -1, 10, -1);
    checks++;
    if (tr_busy[10] !== 1) begin
      errors++; $display("FAIL midrst_scan_before got busy=%0d exp 1", tr_busy[10]);
    end
    sum = tr_busy[11] + tr_conv[11] + tr_chg[11] + tr_chgq[11] + tr_rl[11] + tr_rc[11]
        + tr_img[11] + tr_wei[11];
    checks++;
    if (sum !== 0) begin
      errors++; $display("FAIL midrst_outputs got sum=%0d exp 0", sum);
    end
    checks++;
    if (fin_cnt !== 0) begin
      errors++; $display("FAIL midrst_no_fin got %0d exp 0", fin_cnt);
    end
    capture(2'd0, 8, -1, -1, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tr_img[1+i] !== e00[i]) begin
        errors++; $display("FAIL midrst_replay_img tap%0d got %0d exp %0d", i, tr_img[1+i], e00[i]);
      end
    end
    checks++;
    if ({tr_chg[1], tr_chgq[1], tr_rl[1], tr_rc[1]} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL midrst_replay_first got chg=%0d chgq=%0d rl=%0d rc=%0d exp 1,0,0,0",
                         tr_chg[1], tr_chgq[1], tr_rl[1], tr_rc[1]);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_snapshot();
    capture(2'd0, 45, -1, -1, -1, -1, 5);
    for (int n = 1; n <= 36; n++) begin
      checks++;
      if (tr_img[n] !== model_img(3, 1, 0, n)) begin
        errors++; $display("FAIL snap_img n=%0d got %0d exp %0d", n, tr_img[n], model_img(3, 1, 0, n));
      end
    end
    for (int n = 1; n <= 45; n++) begin
      checks++;
      if (tr_chgq[n] !== exp_chg(n - 1, 36)) begin
        errors++; $display("FAIL snap_chgq_lag n=%0d got %0d exp %0d", n, tr_chgq[n], exp_chg(n - 1, 36));
      end
    end
    checks++;
    if (fin_n !== 39) begin
      errors++; $display("FAIL snap_fin_cycle got %0d exp 39", fin_n);
    end
    img_data = make_img();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start_v  = '0;
    img_data = make_img();
    wei_ones = {3'd1, 3'd1, 3'd1, 3'd1};
    wei_str  = {3'd4, 3'd3, 3'd2, 3'd1};
    test_reset();
    test_default();
    test_padding();
    test_stride();
    test_restart();
    test_reset_mid();
    test_snapshot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
